// File: rtl/if_id_pipe_if.sv
// IF/ID pipeline bus.
// Carries the fetch-side inputs (if_pc, if_instr, if_valid), the hazard
// controls (stall, flush), the PC write enable back to fetch, and the
// registered ID-stage outputs plus status (halted, bubble_cnt).
// master: the fetch/hazard side that drives the inputs.
// slave : the IF/ID pipeline register block.
interface if_id_pipe_if;
    logic [15:0] if_pc;
    logic [15:0] if_instr;
    logic        if_valid;
    logic        stall;
    logic        flush;
    logic        pc_wen;
    logic [15:0] id_pc;
    logic [15:0] id_pc_plus2;
    logic [15:0] id_instr;
    logic        id_valid;
    logic        halted;
    logic [15:0] bubble_cnt;

    modport master (
        output if_pc, if_instr, if_valid, stall, flush,
        input  pc_wen, id_pc, id_pc_plus2, id_instr, id_valid, halted, bubble_cnt
    );

    modport slave (
        input  if_pc, if_instr, if_valid, stall, flush,
        output pc_wen, id_pc, id_pc_plus2, id_instr, id_valid, halted, bubble_cnt
    );
endinterface

// File: rtl/if_id_pipe.sv
// IF/ID pipeline register with stall/flush handling and halt sequencing.
// Ports:
//   clk  - single clock, rising edge
//   rst  - asynchronous active-low reset
//   bus  - if_id_pipe_if.slave: fetch inputs, hazard controls, pc_wen,
//          registered ID outputs, halted flag and bubble counter
//
// state     | meaning
// ----------+-----------------------------------------------------------
// RUN       | normal fetch; capture, stall, flush or bubble each cycle
// HALT_PEND | HLT sits in ID; PC frozen, waiting for stall to drop
// HALTED    | processor stopped; outputs frozen until reset
module if_id_pipe #(
    parameter logic [15:0] NOP    = 16'h0000,
    parameter logic [3:0]  HLT_OP = 4'hF
) (
    input  logic         clk,
    input  logic         rst,
    if_id_pipe_if.slave  bus
);

    typedef enum logic [1:0] {
        RUN       = 2'd0,
        HALT_PEND = 2'd1,
        HALTED    = 2'd2
    } state_t;

    state_t state;

    logic capture;
    logic is_hlt;

    assign is_hlt  = (bus.if_instr[15:12] == HLT_OP);
    assign capture = (state == RUN) && bus.if_valid && !bus.stall && !bus.flush;

    // A flush in HALT_PEND squashes the HLT and redirects fetch, so the
    // PC is written and fetch resumes in RUN.
    assign bus.pc_wen = rst && (state != HALTED) &&
                        (bus.flush || (capture && !is_hlt));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state           <= RUN;
            bus.id_pc       <= 16'h0000;
            bus.id_pc_plus2 <= 16'h0000;
            bus.id_instr    <= NOP;
            bus.id_valid    <= 1'b0;
            bus.halted      <= 1'b0;
            bus.bubble_cnt  <= 16'h0000;
        end else begin
            case (state)
                RUN: begin
                    if (bus.flush || (!bus.stall && !bus.if_valid)) begin
                        bus.id_instr <= NOP;
                        bus.id_valid <= 1'b0;
                        if (bus.bubble_cnt != 16'hFFFF)
                            bus.bubble_cnt <= bus.bubble_cnt + 16'd1;
                    end else if (!bus.stall) begin
                        bus.id_pc       <= bus.if_pc;
                        bus.id_pc_plus2 <= bus.if_pc + 16'd2;
                        bus.id_instr    <= bus.if_instr;
                        bus.id_valid    <= 1'b1;
                        if (is_hlt)
                            state <= HALT_PEND;
                    end
                end
                HALT_PEND: begin
                    if (bus.flush) begin
                        bus.id_instr <= NOP;
                        bus.id_valid <= 1'b0;
                        state        <= RUN;
                    end else if (!bus.stall) begin
                        bus.id_instr <= NOP;
                        bus.id_valid <= 1'b0;
                        bus.halted   <= 1'b1;
                        state        <= HALTED;
                    end
                end
                HALTED: begin
                    bus.id_instr <= NOP;
                    bus.id_valid <= 1'b0;
                    bus.halted   <= 1'b1;
                end
                default: begin
                    state <= RUN;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_if_id_pipe.sv
module tb_if_id_pipe;
    logic clk;
    logic rst;
    int   checks;
    int   failures;

    if_id_pipe_if bus ();

    if_id_pipe dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    task automatic drive(input logic v, input logic [15:0] pc, input logic [15:0] ins,
                         input logic st, input logic fl);
        bus.if_valid = v;
        bus.if_pc    = pc;
        bus.if_instr = ins;
        bus.stall    = st;
        bus.flush    = fl;
    endtask

    task automatic edge_step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        #2;
        rst = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        drive(1'b1, 16'h1234, 16'h5678, 1'b0, 1'b1);
        rst = 1'b0;
        #1;
        checks++;
        if (bus.pc_wen !== 1'b0) begin
            failures++; $display("FAIL reset_pc_wen: got %b want 0", bus.pc_wen);
        end
        checks++;
        if ({bus.id_pc, bus.id_pc_plus2, bus.id_instr, bus.id_valid, bus.halted, bus.bubble_cnt} !== 66'd0) begin
            failures++;
            $display("FAIL reset_outputs: got pc=%h p2=%h ins=%h v=%b h=%b cnt=%h want all zero",
                     bus.id_pc, bus.id_pc_plus2, bus.id_instr, bus.id_valid, bus.halted, bus.bubble_cnt);
        end
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_capture();
        drive(1'b1, 16'h0000, 16'h1234, 1'b0, 1'b0);
        #1;
        checks++;
        if (bus.pc_wen !== 1'b1) begin
            failures++; $display("FAIL capture_pc_wen: got %b want 1", bus.pc_wen);
        end
        edge_step();
        checks++;
        if ({bus.id_pc, bus.id_pc_plus2, bus.id_instr, bus.id_valid} !== {16'h0000, 16'h0002, 16'h1234, 1'b1}) begin
            failures++;
            $display("FAIL capture_id: got pc=%h p2=%h ins=%h v=%b want 0000 0002 1234 1",
                     bus.id_pc, bus.id_pc_plus2, bus.id_instr, bus.id_valid);
        end
    endtask

    task automatic test_stall();
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 16'($urandom), 16'($urandom_range(0, 16'hEFFF)), 1'b1, 1'b0);
            #1;
            checks++;
            if (bus.pc_wen !== 1'b0) begin
                failures++; $display("FAIL stall_pc_wen: got %b want 0", bus.pc_wen);
            end
            edge_step();
            checks++;
            if ({bus.id_pc, bus.id_pc_plus2, bus.id_instr, bus.id_valid, bus.bubble_cnt} !==
                {16'h0000, 16'h0002, 16'h1234, 1'b1, 16'h0000}) begin
                failures++;
                $display("FAIL stall_hold: got pc=%h p2=%h ins=%h v=%b cnt=%h want 0000 0002 1234 1 0000",
                         bus.id_pc, bus.id_pc_plus2, bus.id_instr, bus.id_valid, bus.bubble_cnt);
            end
        end
    endtask

    task automatic test_stall_flush();
        drive(1'b1, 16'h0040, 16'h4321, 1'b1, 1'b1);
        #1;
        checks++;
        if (bus.pc_wen !== 1'b1) begin
            failures++; $display("FAIL stall_flush_pc_wen: got %b want 1", bus.pc_wen);
        end
        edge_step();
        checks++;
        if ({bus.id_pc, bus.id_pc_plus2, bus.id_instr, bus.id_valid, bus.bubble_cnt} !==
            {16'h0000, 16'h0002, 16'h0000, 1'b0, 16'h0001}) begin
            failures++;
            $display("FAIL stall_flush_bubble: got pc=%h p2=%h ins=%h v=%b cnt=%h want 0000 0002 0000 0 0001",
                     bus.id_pc, bus.id_pc_plus2, bus.id_instr, bus.id_valid, bus.bubble_cnt);
        end
    endtask

    task automatic test_wrap_and_flush_hlt();
        drive(1'b1, 16'hFFFE, 16'h5A5A, 1'b0, 1'b0);
        edge_step();
        checks++;
        if ({bus.id_pc, bus.id_pc_plus2, bus.id_instr} !== {16'hFFFE, 16'h0000, 16'h5A5A}) begin
            failures++;
            $display("FAIL wrap_plus2: got pc=%h p2=%h ins=%h want fffe 0000 5a5a",
                     bus.id_pc, bus.id_pc_plus2, bus.id_instr);
        end
        drive(1'b1, 16'h0000, 16'hF123, 1'b0, 1'b1);
        #1;
        checks++;
        if (bus.pc_wen !== 1'b1) begin
            failures++; $display("FAIL flush_hlt_pc_wen: got %b want 1", bus.pc_wen);
        end
        edge_step();
        checks++;
        if ({bus.halted, bus.id_valid, bus.bubble_cnt} !== {1'b0, 1'b0, 16'h0002}) begin
            failures++;
            $display("FAIL flush_hlt_discard: got h=%b v=%b cnt=%h want 0 0 0002",
                     bus.halted, bus.id_valid, bus.bubble_cnt);
        end
        drive(1'b1, 16'h0020, 16'h7777, 1'b0, 1'b0);
        #1;
        checks++;
        if (bus.pc_wen !== 1'b1) begin
            failures++; $display("FAIL flush_hlt_still_run: got pc_wen %b want 1", bus.pc_wen);
        end
        edge_step();
        checks++;
        if ({bus.id_pc, bus.id_instr, bus.id_valid} !== {16'h0020, 16'h7777, 1'b1}) begin
            failures++;
            $display("FAIL flush_hlt_next_capture: got pc=%h ins=%h v=%b want 0020 7777 1",
                     bus.id_pc, bus.id_instr, bus.id_valid);
        end
    endtask

    task automatic test_halt();
        drive(1'b1, 16'h0010, 16'hF000, 1'b0, 1'b0);
        #1;
        checks++;
        if (bus.pc_wen !== 1'b0) begin
            failures++; $display("FAIL halt_capture_pc_wen: got %b want 0", bus.pc_wen);
        end
        edge_step();
        checks++;
        if ({bus.id_pc, bus.id_instr, bus.id_valid, bus.halted} !== {16'h0010, 16'hF000, 1'b1, 1'b0}) begin
            failures++;
            $display("FAIL halt_loaded: got pc=%h ins=%h v=%b h=%b want 0010 f000 1 0",
                     bus.id_pc, bus.id_instr, bus.id_valid, bus.halted);
        end
        drive(1'b1, 16'h0012, 16'h2222, 1'b1, 1'b0);
        edge_step();
        checks++;
        if ({bus.id_instr, bus.id_valid, bus.halted, bus.pc_wen} !== {16'hF000, 1'b1, 1'b0, 1'b0}) begin
            failures++;
            $display("FAIL halt_pend_stall: got ins=%h v=%b h=%b pcw=%b want f000 1 0 0",
                     bus.id_instr, bus.id_valid, bus.halted, bus.pc_wen);
        end
        drive(1'b1, 16'h0012, 16'h3333, 1'b0, 1'b0);
        #1;
        checks++;
        if (bus.pc_wen !== 1'b0) begin
            failures++; $display("FAIL halt_pend_pc_wen: got %b want 0", bus.pc_wen);
        end
        edge_step();
        checks++;
        if ({bus.id_instr, bus.id_valid, bus.halted, bus.bubble_cnt} !== {16'h0000, 1'b0, 1'b1, 16'h0002}) begin
            failures++;
            $display("FAIL halt_enter: got ins=%h v=%b h=%b cnt=%h want 0000 0 1 0002",
                     bus.id_instr, bus.id_valid, bus.halted, bus.bubble_cnt);
        end
        for (int i = 0; i < 4; i++) begin
            drive(1'($urandom), 16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom));
            #1;
            checks++;
            if (bus.pc_wen !== 1'b0) begin
                failures++; $display("FAIL halted_pc_wen: got %b want 0", bus.pc_wen);
            end
            edge_step();
            checks++;
            if ({bus.id_instr, bus.id_valid, bus.halted, bus.bubble_cnt} !== {16'h0000, 1'b0, 1'b1, 16'h0002}) begin
                failures++;
                $display("FAIL halted_frozen: got ins=%h v=%b h=%b cnt=%h want 0000 0 1 0002",
                         bus.id_instr, bus.id_valid, bus.halted, bus.bubble_cnt);
            end
        end
        do_reset();
        checks++;
        if (bus.halted !== 1'b0) begin
            failures++; $display("FAIL halted_exit_reset: got %b want 0", bus.halted);
        end
    endtask

    task automatic test_async_reset();
        drive(1'b1, 16'h0030, 16'hABCD, 1'b0, 1'b0);
        edge_step();
        drive(1'b1, 16'h0032, 16'hF00F, 1'b0, 1'b0);
        edge_step();
        drive(1'b1, 16'h0034, 16'h1111, 1'b1, 1'b1);
        #2;
        rst = 1'b0;
        #1;
        checks++;
        if ({bus.id_pc, bus.id_pc_plus2, bus.id_instr, bus.id_valid, bus.halted, bus.bubble_cnt, bus.pc_wen} !== 67'd0) begin
            failures++;
            $display("FAIL async_reset: got pc=%h p2=%h ins=%h v=%b h=%b cnt=%h pcw=%b want all zero",
                     bus.id_pc, bus.id_pc_plus2, bus.id_instr, bus.id_valid, bus.halted, bus.bubble_cnt, bus.pc_wen);
        end
        @(negedge clk);
        rst = 1'b1;
        drive(1'b1, 16'h0004, 16'h1111, 1'b0, 1'b0);
        edge_step();
        checks++;
        if ({bus.id_pc, bus.id_instr, bus.id_valid, bus.halted} !== {16'h0004, 16'h1111, 1'b1, 1'b0}) begin
            failures++;
            $display("FAIL reset_then_run: got pc=%h ins=%h v=%b h=%b want 0004 1111 1 0",
                     bus.id_pc, bus.id_instr, bus.id_valid, bus.halted);
        end
    endtask

    // Reference model: ID contents and a phase tag (0 running, 1 halt
    // pending, 2 halted), updated from the behavioural rules per cycle.
    task automatic test_random();
        logic [15:0] m_pc, m_p2, m_ins, m_cnt;
        logic        m_v, m_h, exp_pcw;
        int          phase, halted_cycles;
        logic        v, st, fl;
        logic [15:0] pc, ins;
        do_reset();
        m_pc = 0; m_p2 = 0; m_ins = 0; m_cnt = 0; m_v = 0; m_h = 0;
        phase = 0; halted_cycles = 0;
        for (int i = 0; i < 300; i++) begin
            if ((phase == 2 && halted_cycles >= 3) || $urandom_range(0, 59) == 0) begin
                do_reset();
                m_pc = 0; m_p2 = 0; m_ins = 0; m_cnt = 0; m_v = 0; m_h = 0;
                phase = 0; halted_cycles = 0;
            end
            v   = ($urandom_range(0, 3) != 0);
            st  = ($urandom_range(0, 3) == 0);
            fl  = ($urandom_range(0, 6) == 0) && (phase != 1);
            pc  = 16'($urandom_range(0, 32767)) << 1;
            ins = 16'($urandom);
            if ($urandom_range(0, 7) == 0) ins[15:12] = 4'hF;
            else if (ins[15:12] == 4'hF) ins[15:12] = 4'h3;
            drive(v, pc, ins, st, fl);
            exp_pcw = (phase != 2) && (fl || (phase == 0 && v && !st && ins[15:12] != 4'hF));
            #1;
            checks++;
            if (bus.pc_wen !== exp_pcw) begin
                failures++; $display("FAIL rand_pc_wen[%0d]: got %b want %b", i, bus.pc_wen, exp_pcw);
            end
            if (phase == 2) begin
                halted_cycles++;
            end else if (fl) begin
                m_ins = 16'h0000; m_v = 0;
                if (phase == 0 && m_cnt != 16'hFFFF) m_cnt = m_cnt + 1;
                phase = 0;
            end else if (!st) begin
                if (phase == 1) begin
                    m_ins = 16'h0000; m_v = 0; m_h = 1; phase = 2;
                end else if (v) begin
                    m_pc = pc; m_p2 = pc + 16'd2; m_ins = ins; m_v = 1;
                    if (ins[15:12] == 4'hF) phase = 1;
                end else begin
                    m_ins = 16'h0000; m_v = 0;
                    if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 1;
                end
            end
            edge_step();
            checks++;
            if ({bus.id_pc, bus.id_pc_plus2, bus.id_instr, bus.id_valid, bus.halted, bus.bubble_cnt} !==
                {m_pc, m_p2, m_ins, m_v, m_h, m_cnt}) begin
                failures++;
                $display("FAIL rand_id[%0d]: got pc=%h p2=%h ins=%h v=%b h=%b cnt=%h want pc=%h p2=%h ins=%h v=%b h=%b cnt=%h",
                         i, bus.id_pc, bus.id_pc_plus2, bus.id_instr, bus.id_valid, bus.halted, bus.bubble_cnt,
                         m_pc, m_p2, m_ins, m_v, m_h, m_cnt);
            end
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst      = 1'b1;
        drive(1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0);
        test_reset();
        test_capture();
        test_stall();
        test_stall_flush();
        test_wrap_and_flush_hlt();
        test_halt();
        test_async_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/if_id_pipe.md
IF_ID_PIPE -- requirements
Module: if_id_pipe

Interface
REQ-001 Parameter: NOP, 16'h0000, instruction word loaded into ID on a bubble.
REQ-002 Parameter: HLT_OP, 4'hF, opcode (instr[15:12]) that halts fetch.
REQ-003 Port: clk  input  1  single clock; all state updates on its rising edge.
REQ-004 Port: rst  input  1  asynchronous, active-low reset.
REQ-005 Port: if_pc  input  16  PC of the word being fetched (PC register output).
REQ-006 Port: if_instr  input  16  fetched instruction word.
REQ-007 Port: if_valid  input  1  if_instr valid this cycle (imem ready).
REQ-008 Port: stall  input  1  hazard unit: hold ID contents and PC.
REQ-009 Port: flush  input  1  taken branch resolved in ID: squash the fetched word, load branch target.
REQ-010 Port: pc_wen  output  1  write enable to the PC register (combinational).
REQ-011 Port: id_pc  output  16  registered PC of the ID instruction.
REQ-012 Port: id_pc_plus2  output  16  registered if_pc+2.
REQ-013 Port: id_instr  output  16  registered instruction.
REQ-014 Port: id_valid  output  1  ID holds a real instruction.
REQ-015 Port: halted  output  1  processor halted.
REQ-016 Port: bubble_cnt  output  16  count of bubble cycles.

Function
REQ-017 The block SHALL implement states RUN, HALT_PEND, HALTED.
REQ-018 "capture" SHALL mean state==RUN & if_valid & !stall & !flush.
REQ-019 On a capture the block SHALL load id_pc=if_pc, id_pc_plus2=if_pc+2 (mod 2^16; 16'hFFFE gives 16'h0000), id_instr=if_instr, id_valid=1 at the next edge.
REQ-020 pc_wen SHALL be flush | (capture & if_instr[15:12]!=HLT_OP); the PC is not advanced past a HLT.
REQ-021 flush=1 SHALL take priority over stall=1 in every state except HALTED: next edge loads id_instr=NOP, id_valid=0, id_pc and id_pc_plus2 unchanged.
REQ-022 stall=1 with flush=0 SHALL hold all ID registers and drive pc_wen=0.
REQ-023 RUN, if_valid=0, stall=0, flush=0: next edge SHALL load a bubble (NOP, id_valid=0).
REQ-024 RUN -> HALT_PEND when a capture has if_instr[15:12]==HLT_OP; the HLT is loaded into ID.
REQ-025 In HALT_PEND pc_wen SHALL be 0 and no new word captured; stall=1 holds HLT in ID; stall=0 loads a bubble and moves to HALTED.
REQ-026 A HLT fetched in the same cycle as flush=1 SHALL be discarded and state SHALL stay RUN.
REQ-027 HALTED SHALL drive halted=1, pc_wen=0, id_valid=0, id_instr=NOP, ignore all inputs, and exit only via reset.
REQ-028 bubble_cnt SHALL increment by 1 on each edge where state==RUN and the loaded ID entry is a bubble (REQ-021, REQ-023), saturating at 16'hFFFF.
REQ-029 halted SHALL be a registered decode of state==HALTED; no other output depends combinationally on if_instr except pc_wen.

Reset
REQ-030 rst=0 SHALL immediately, independent of clk, set state=RUN, id_pc=0, id_pc_plus2=0, id_instr=NOP, id_valid=0, halted=0, bubble_cnt=0.
REQ-031 Reset asserted mid-HALT_PEND or mid-stall SHALL discard all pending state; the first edge after rst rises behaves as RUN from empty.
REQ-032 pc_wen SHALL evaluate to 0 while rst=0.

Verification
REQ-033 Reset then if_valid=1, if_pc=16'h0000, if_instr=16'h1234 for one edge -> id_pc=0, id_pc_plus2=2, id_instr=16'h1234, id_valid=1, pc_wen=1 before the edge.
REQ-034 ID loaded, stall=1 for 3 cycles with changing if_instr -> ID outputs unchanged, pc_wen=0, bubble_cnt unchanged.
REQ-035 stall=1 and flush=1 together -> pc_wen=1, next edge id_valid=0, id_instr=NOP, bubble_cnt+1.
REQ-036 if_instr=16'hF000 captured at if_pc=16'h0010 -> pc_wen=0, id_instr=16'hF000; next edge with stall=0 -> id_valid=0; halted=1 after that edge, stays 1 with any inputs until rst=0.
REQ-037 if_pc=16'hFFFE captured -> id_pc_plus2=16'h0000; HLT word with flush=1 -> state stays RUN, halted=0.
REQ-038 rst pulsed low between clock edges during HALT_PEND -> all outputs at reset values immediately, before any edge.
